// File: rtl/deserializer_pkg.sv
// Shared constants and types for the serial-to-parallel deserializer.
// Holds the default frame length, the FSM state encoding and the counter-width helper.
package deserializer_pkg;

    localparam int unsigned LENGTH_DEF = 24;

    // Width needed to hold a bit count of 0..len inclusive.
    function automatic int unsigned cnt_width(input int unsigned len);
        return $clog2(len + 1);
    endfunction

    localparam int unsigned CNT_W_DEF = cnt_width(LENGTH_DEF);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/deserializer_if.sv
// Serial input, parallel output and status signals of the deserializer.
// The master side feeds bits and consumes words; the slave side is the deserializer.
interface deserializer_if
    import deserializer_pkg::*;
#(
    parameter int unsigned LENGTH = LENGTH_DEF
);
    logic              i_en;
    logic              i_din_valid;
    logic              i_din;
    logic              i_sof;
    logic              i_dout_ready;
    logic [LENGTH-1:0] ov_dout;
    logic              o_dout_valid;
    logic              o_busy;
    logic              o_sync_err;
    logic              o_overrun;

    modport master (
        output i_en, i_din_valid, i_din, i_sof, i_dout_ready,
        input  ov_dout, o_dout_valid, o_busy, o_sync_err, o_overrun
    );

    modport slave (
        input  i_en, i_din_valid, i_din, i_sof, i_dout_ready,
        output ov_dout, o_dout_valid, o_busy, o_sync_err, o_overrun
    );
endinterface

// File: rtl/deserializer.sv
// LSB-first serial-to-parallel converter with frame sync on i_sof,
// a valid/ready output register, a sync-error pulse and a sticky overrun flag.
module deserializer
    import deserializer_pkg::*;
#(
    parameter int unsigned LENGTH = LENGTH_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    deserializer_if.slave bus
);

    localparam int unsigned CNT_W = cnt_width(LENGTH);

    state_t            r_state;
    logic [CNT_W-1:0]  r_count;
    logic [LENGTH-1:0] r_shift;
    logic [LENGTH-1:0] r_dout;
    logic              r_dout_valid;
    logic              r_busy;
    logic              r_sync_err;
    logic              r_overrun;

    logic              w_accept;
    logic              w_complete;
    logic              w_load_ok;
    logic [LENGTH-1:0] w_word;

    // Current bit merged into the partial frame; r_shift is zero in IDLE so this
    // also forms the single-bit word when LENGTH is 1.
    always_comb begin
        w_accept          = bus.i_en & bus.i_din_valid;
        w_word            = r_shift;
        w_word[r_count]   = bus.i_din;
        w_load_ok         = ~r_dout_valid | bus.i_dout_ready;
        w_complete        = 1'b0;
        if (w_accept) begin
            if (r_state == ST_IDLE)
                w_complete = bus.i_sof & (LENGTH == 1);
            else
                w_complete = ~bus.i_sof & (r_count == CNT_W'(LENGTH - 1));
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_count      <= '0;
            r_shift      <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_sync_err   <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_sync_err <= 1'b0;

            // Capture FSM: only accepted bits move the shift register and counter
            if (w_accept) begin
                case (r_state)
                    ST_IDLE: begin
                        if (bus.i_sof) begin
                            if (w_complete) begin
                                r_shift <= '0;
                                r_count <= '0;
                            end else begin
                                r_shift <= LENGTH'(bus.i_din);
                                r_count <= CNT_W'(1);
                                r_state <= ST_SHIFT;
                                r_busy  <= 1'b1;
                            end
                        end
                    end
                    ST_SHIFT: begin
                        if (bus.i_sof) begin
                            r_sync_err <= 1'b1;
                            r_shift    <= LENGTH'(bus.i_din);
                            r_count    <= CNT_W'(1);
                        end else if (w_complete) begin
                            r_shift <= '0;
                            r_count <= '0;
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_shift <= w_word;
                            r_count <= r_count + CNT_W'(1);
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end

            // Output register: a word completing against a stalled consumer is dropped
            if (w_complete) begin
                if (w_load_ok) begin
                    r_dout       <= w_word;
                    r_dout_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_dout_valid && bus.i_dout_ready) begin
                r_dout_valid <= 1'b0;
            end
        end
    end

    assign bus.ov_dout      = r_dout;
    assign bus.o_dout_valid = r_dout_valid;
    assign bus.o_busy       = r_busy;
    assign bus.o_sync_err   = r_sync_err;
    assign bus.o_overrun    = r_overrun;

endmodule

// File: tb/tb_deserializer.sv
// Directed self-checking bench for the 24-bit deserializer.
module tb_deserializer;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    deserializer_if #(.LENGTH(24)) bus ();

    deserializer #(.LENGTH(24)) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic send_bit(input logic b, input logic sof);
        bus.i_en        = 1'b1;
        bus.i_din_valid = 1'b1;
        bus.i_din       = b;
        bus.i_sof       = sof;
        @(posedge clk);
        #1;
    endtask

    // Sends bits lo..hi of w; i_sof accompanies bit lo when sof_first is set.
    task automatic send_range(input logic [23:0] w, input int lo, input int hi, input logic sof_first);
        for (int k = lo; k <= hi; k++)
            send_bit(w[k], sof_first && (k == lo));
    endtask

    task automatic idle(input int n);
        bus.i_din_valid = 1'b0;
        bus.i_sof       = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_checks         = 0;
        n_pass           = 0;
        rst_n            = 1'b0;
        bus.i_en         = 1'b0;
        bus.i_din_valid  = 1'b0;
        bus.i_din        = 1'b0;
        bus.i_sof        = 1'b0;
        bus.i_dout_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout",     32'(bus.ov_dout), 32'h0);
        chk("rst_valid",    32'(bus.o_dout_valid), 32'h0);
        chk("rst_busy",     32'(bus.o_busy), 32'h0);
        chk("rst_sync",     32'(bus.o_sync_err), 32'h0);
        chk("rst_overrun",  32'(bus.o_overrun), 32'h0);
        rst_n = 1'b1;
        idle(1);

        // Bits without i_sof in IDLE are ignored
        send_range(24'hFFFFFF, 0, 3, 1'b0);
        chk("idle_no_sof_busy", 32'(bus.o_busy), 32'h0);
        chk("idle_no_sof_valid", 32'(bus.o_dout_valid), 32'h0);

        // Basic frame with consumer ready
        send_range(24'hA5C3F1, 0, 0, 1'b1);
        chk("f1_busy_bit0", 32'(bus.o_busy), 32'h1);
        send_range(24'hA5C3F1, 1, 22, 1'b0);
        chk("f1_valid_bit22", 32'(bus.o_dout_valid), 32'h0);
        send_bit(1'b1, 1'b0);
        chk("f1_dout", 32'(bus.ov_dout), 32'h00A5C3F1);
        chk("f1_valid", 32'(bus.o_dout_valid), 32'h1);
        chk("f1_busy_done", 32'(bus.o_busy), 32'h0);
        idle(1);
        chk("f1_valid_drop", 32'(bus.o_dout_valid), 32'h0);
        chk("f1_dout_hold", 32'(bus.ov_dout), 32'h00A5C3F1);

        // Stall of three cycles between bits 5 and 6
        send_range(24'h0F0F0F, 0, 5, 1'b1);
        bus.i_en = 1'b0; bus.i_din = 1'b1; bus.i_sof = 1'b1;
        @(posedge clk); #1;
        bus.i_en = 1'b1; bus.i_din_valid = 1'b0;
        @(posedge clk); #1;
        bus.i_en = 1'b0; bus.i_din_valid = 1'b1;
        @(posedge clk); #1;
        chk("gap_busy", 32'(bus.o_busy), 32'h1);
        send_range(24'h0F0F0F, 6, 23, 1'b0);
        chk("gap_dout", 32'(bus.ov_dout), 32'h000F0F0F);
        chk("gap_valid", 32'(bus.o_dout_valid), 32'h1);
        idle(1);

        // Mid-frame resync
        send_range(24'h0003FF, 0, 9, 1'b1);
        chk("sync_pre", 32'(bus.o_sync_err), 32'h0);
        send_bit(1'b0, 1'b1);
        chk("sync_pulse", 32'(bus.o_sync_err), 32'h1);
        chk("sync_busy", 32'(bus.o_busy), 32'h1);
        send_bit(1'b1, 1'b0);
        chk("sync_clear", 32'(bus.o_sync_err), 32'h0);
        send_range(24'h123456, 2, 23, 1'b0);
        chk("sync_dout", 32'(bus.ov_dout), 32'h00123456);
        chk("sync_valid", 32'(bus.o_dout_valid), 32'h1);
        idle(1);

        // Overrun: consumer stalled across two completions
        bus.i_dout_ready = 1'b0;
        send_range(24'h000001, 0, 23, 1'b1);
        chk("ovr_first_dout", 32'(bus.ov_dout), 32'h00000001);
        chk("ovr_first_flag", 32'(bus.o_overrun), 32'h0);
        idle(2);
        chk("ovr_hold_valid", 32'(bus.o_dout_valid), 32'h1);
        send_range(24'hFFFFFF, 0, 23, 1'b1);
        chk("ovr_dout", 32'(bus.ov_dout), 32'h00000001);
        chk("ovr_flag", 32'(bus.o_overrun), 32'h1);
        chk("ovr_valid", 32'(bus.o_dout_valid), 32'h1);
        idle(1);
        chk("ovr_sticky", 32'(bus.o_overrun), 32'h1);

        // Asynchronous reset mid-frame
        bus.i_dout_ready = 1'b1;
        send_range(24'h5A5A5A, 0, 12, 1'b1);
        chk("rst_mid_busy", 32'(bus.o_busy), 32'h1);
        bus.i_din_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_dout",    32'(bus.ov_dout), 32'h0);
        chk("rst_mid_valid",   32'(bus.o_dout_valid), 32'h0);
        chk("rst_mid_busy0",   32'(bus.o_busy), 32'h0);
        chk("rst_mid_sync",    32'(bus.o_sync_err), 32'h0);
        chk("rst_mid_overrun", 32'(bus.o_overrun), 32'h0);
        idle(2);
        rst_n = 1'b1;
        send_range(24'h5A5A5A, 13, 23, 1'b0);
        chk("rst_resume_busy", 32'(bus.o_busy), 32'h0);
        chk("rst_resume_valid", 32'(bus.o_dout_valid), 32'h0);
        send_range(24'h800000, 0, 23, 1'b1);
        chk("rst_after_dout", 32'(bus.ov_dout), 32'h00800000);
        chk("rst_after_valid", 32'(bus.o_dout_valid), 32'h1);
        idle(1);
        chk("rst_after_drop", 32'(bus.o_dout_valid), 32'h0);

        // Ready rises on the very edge that completes the next frame
        bus.i_dout_ready = 1'b0;
        send_range(24'h5A5A5A, 0, 23, 1'b1);
        chk("rdy_first_dout", 32'(bus.ov_dout), 32'h005A5A5A);
        send_range(24'hABCDEF, 0, 22, 1'b1);
        bus.i_dout_ready = 1'b1;
        send_bit(1'b1, 1'b0);
        chk("rdy_valid", 32'(bus.o_dout_valid), 32'h1);
        chk("rdy_dout", 32'(bus.ov_dout), 32'h00ABCDEF);
        chk("rdy_overrun", 32'(bus.o_overrun), 32'h0);
        idle(1);
        chk("rdy_drop", 32'(bus.o_dout_valid), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
